// File: rtl/freq_acq_ctrl.sv
// Frequency-acquisition controller: counts comparator pulses over fixed windows and
// binary-searches the DCO coarse code, flagging acqDone after repeated in-band windows.
module freq_acq_ctrl #(
  parameter int unsigned CODE_W     = 8,
  parameter int unsigned INIT_CODE  = 128,
  parameter int unsigned INIT_STEP  = 32,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned WIN_CYC    = 32,
  parameter int unsigned HYST       = 2,
  parameter int unsigned LOCK_WINS  = 4
) (
  input  logic              refClk,
  input  logic              reset,
  input  logic              enable,
  input  logic              freqInc,
  input  logic              freqDec,
  output logic              cmpEnable,
  output logic [CODE_W-1:0] dcoCode,
  output logic              acqDone
);

  localparam int unsigned CNT_W   = $clog2(WIN_CYC + 1);
  localparam int unsigned CYC_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned LOCK_W  = $clog2(LOCK_WINS + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DECIDE} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  state_t            state, state_nxt;
  dir_t              prev_dir, prev_nxt, dir_new;
  logic [CYC_W-1:0]  cyc_cnt, cyc_nxt;
  logic [CNT_W-1:0]  inc_cnt, inc_nxt, dec_cnt, dec_nxt;
  logic [CODE_W-1:0] step, step_nxt, step_half, step_eff, code_nxt, code_adj;
  logic [CODE_W:0]   up_sum;
  logic [LOCK_W-1:0] inband_cnt, inband_nxt, inband_inc;
  logic              done_nxt, cmp_nxt, win_up, win_dn;

  // State and datapath registers
  always_ff @(posedge refClk) begin
    if (reset) begin
      state      <= IDLE;
      prev_dir   <= DIR_NONE;
      cyc_cnt    <= '0;
      inc_cnt    <= '0;
      dec_cnt    <= '0;
      step       <= CODE_W'(INIT_STEP);
      inband_cnt <= '0;
      dcoCode    <= CODE_W'(INIT_CODE);
      acqDone    <= 1'b0;
      cmpEnable  <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev_dir   <= prev_nxt;
      cyc_cnt    <= cyc_nxt;
      inc_cnt    <= inc_nxt;
      dec_cnt    <= dec_nxt;
      step       <= step_nxt;
      inband_cnt <= inband_nxt;
      dcoCode    <= code_nxt;
      acqDone    <= done_nxt;
      cmpEnable  <= cmp_nxt;
    end
  end

  // Next-state and window decision
  always_comb begin
    state_nxt  = state;
    prev_nxt   = prev_dir;
    cyc_nxt    = cyc_cnt;
    inc_nxt    = inc_cnt;
    dec_nxt    = dec_cnt;
    step_nxt   = step;
    inband_nxt = inband_cnt;
    code_nxt   = dcoCode;
    done_nxt   = acqDone;

    win_up  = 32'(inc_cnt) > 32'(dec_cnt) + HYST;
    win_dn  = 32'(dec_cnt) > 32'(inc_cnt) + HYST;
    dir_new = win_up ? DIR_UP : DIR_DN;

    // A lost lock drops to unit steps; otherwise halve on each reversal
    step_half = (step > CODE_W'(1)) ? (step >> 1) : CODE_W'(1);
    if (acqDone)
      step_eff = CODE_W'(1);
    else if (prev_dir != DIR_NONE && prev_dir != dir_new)
      step_eff = step_half;
    else
      step_eff = step;

    up_sum = {1'b0, dcoCode} + {1'b0, step_eff};
    if (win_up)
      code_adj = up_sum[CODE_W] ? {CODE_W{1'b1}} : up_sum[CODE_W-1:0];
    else
      code_adj = (step_eff > dcoCode) ? '0 : dcoCode - step_eff;

    inband_inc = (inband_cnt == LOCK_W'(LOCK_WINS)) ? inband_cnt : inband_cnt + LOCK_W'(1);

    case (state)
      IDLE: begin
        step_nxt   = CODE_W'(INIT_STEP);
        prev_nxt   = DIR_NONE;
        inband_nxt = '0;
        done_nxt   = 1'b0;
        cyc_nxt    = '0;
        inc_nxt    = '0;
        dec_nxt    = '0;
        if (enable) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cyc_cnt == CYC_W'(SETTLE_CYC - 1)) begin
          state_nxt = SAMPLE;
          cyc_nxt   = '0;
          inc_nxt   = '0;
          dec_nxt   = '0;
        end else begin
          cyc_nxt = cyc_cnt + CYC_W'(1);
        end
      end
      SAMPLE: begin
        if (freqInc && !freqDec) inc_nxt = inc_cnt + CNT_W'(1);
        if (freqDec && !freqInc) dec_nxt = dec_cnt + CNT_W'(1);
        if (cyc_cnt == CYC_W'(WIN_CYC - 1)) begin
          state_nxt = DECIDE;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc_cnt + CYC_W'(1);
        end
      end
      DECIDE: begin
        state_nxt = SETTLE;
        cyc_nxt   = '0;
        if (win_up || win_dn) begin
          step_nxt   = step_eff;
          code_nxt   = code_adj;
          prev_nxt   = dir_new;
          inband_nxt = '0;
          done_nxt   = 1'b0;
        end else begin
          inband_nxt = inband_inc;
          if (inband_inc == LOCK_W'(LOCK_WINS)) done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Disable aborts any state, holding the code and clearing acquisition progress
    if (!enable) begin
      state_nxt  = IDLE;
      cyc_nxt    = '0;
      inc_nxt    = '0;
      dec_nxt    = '0;
      code_nxt   = dcoCode;
      step_nxt   = CODE_W'(INIT_STEP);
      prev_nxt   = DIR_NONE;
      inband_nxt = '0;
      done_nxt   = 1'b0;
    end

    cmp_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_freq_acq_ctrl.sv
// Self-checking bench for freq_acq_ctrl: directed window table, hand-written enable/reset
// sequences, and randomized windows against a window-level reference model.
module tb_freq_acq_ctrl;

  localparam int unsigned CODE_W     = 8;
  localparam int unsigned INIT_CODE  = 128;
  localparam int unsigned INIT_STEP  = 32;
  localparam int unsigned SETTLE_CYC = 16;
  localparam int unsigned WIN_CYC    = 32;
  localparam int unsigned HYST       = 2;
  localparam int unsigned LOCK_WINS  = 4;
  localparam int          CODE_MAX   = (1 << CODE_W) - 1;

  logic              refClk, reset, enable, freqInc, freqDec;
  logic              cmpEnable, acqDone;
  logic [CODE_W-1:0] dcoCode;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_code, m_step, m_prev, m_inband;
  bit m_done;
  bit w_inc [WIN_CYC];
  bit w_dec [WIN_CYC];

  typedef struct {
    bit rst;
    int ni;
    int nd;
    int nb;
    int code;
    bit done;
  } vec_t;
  vec_t tbl[$];

  freq_acq_ctrl #(
    .CODE_W(CODE_W), .INIT_CODE(INIT_CODE), .INIT_STEP(INIT_STEP), .SETTLE_CYC(SETTLE_CYC),
    .WIN_CYC(WIN_CYC), .HYST(HYST), .LOCK_WINS(LOCK_WINS)
  ) dut (
    .refClk(refClk), .reset(reset), .enable(enable), .freqInc(freqInc), .freqDec(freqDec),
    .cmpEnable(cmpEnable), .dcoCode(dcoCode), .acqDone(acqDone)
  );

  initial refClk = 1'b0;
  always #5 refClk = ~refClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int code, input bit done, input bit cmp);
    check({tag, " dcoCode"}, int'(dcoCode), code);
    check({tag, " acqDone"}, int'(acqDone), int'(done));
    check({tag, " cmpEnable"}, int'(cmpEnable), int'(cmp));
  endtask

  task automatic model_reset();
    m_code = INIT_CODE; m_step = INIT_STEP; m_prev = 0; m_inband = 0; m_done = 0;
  endtask

  task automatic model_disable();
    m_step = INIT_STEP; m_prev = 0; m_inband = 0; m_done = 0;
  endtask

  // Window-level behaviour: count legal pulses, classify, then apply the correction rules
  task automatic model_window();
    int ni, nd, dir;
    ni = 0; nd = 0;
    for (int i = 0; i < WIN_CYC; i++) begin
      if (w_inc[i] && !w_dec[i]) ni++;
      if (w_dec[i] && !w_inc[i]) nd++;
    end
    if (ni > nd + int'(HYST)) dir = 1;
    else if (nd > ni + int'(HYST)) dir = -1;
    else dir = 0;
    if (dir == 0) begin
      if (m_inband < int'(LOCK_WINS)) m_inband++;
      if (m_inband == int'(LOCK_WINS)) m_done = 1;
    end else begin
      if (m_done) begin
        m_step = 1;
        m_done = 0;
      end else if (m_prev != 0 && m_prev != dir) begin
        m_step = (m_step / 2 > 1) ? m_step / 2 : 1;
      end
      m_code = m_code + dir * m_step;
      if (m_code < 0) m_code = 0;
      if (m_code > CODE_MAX) m_code = CODE_MAX;
      m_prev = dir;
      m_inband = 0;
    end
  endtask

  task automatic fill(input int ni, input int nd, input int nb);
    for (int i = 0; i < WIN_CYC; i++) begin
      w_inc[i] = (i < ni) || (i >= ni + nd && i < ni + nd + nb);
      w_dec[i] = (i >= ni && i < ni + nd + nb);
    end
  endtask

  task automatic fill_random(input int pi, input int pd);
    for (int i = 0; i < WIN_CYC; i++) begin
      w_inc[i] = ($urandom_range(0, 15) < pi);
      w_dec[i] = ($urandom_range(0, 15) < pd);
    end
  endtask

  // Entered at the negedge just after SETTLE entry; returns at the same point one period later
  task automatic run_window();
    for (int i = 0; i < int'(SETTLE_CYC); i++) begin
      freqInc = 1'($urandom_range(0, 1));
      freqDec = 1'($urandom_range(0, 1));
      @(negedge refClk);
    end
    for (int i = 0; i < int'(WIN_CYC); i++) begin
      freqInc = w_inc[i];
      freqDec = w_dec[i];
      @(negedge refClk);
    end
    freqInc = 1'($urandom_range(0, 1));
    freqDec = 1'($urandom_range(0, 1));
    @(negedge refClk);
    freqInc = 1'b0;
    freqDec = 1'b0;
  endtask

  task automatic restart();
    reset = 1'b1; enable = 1'b1; freqInc = 1'b0; freqDec = 1'b0;
    @(negedge refClk);
    reset = 1'b0;
    @(negedge refClk);
    model_reset();
  endtask

  task automatic do_window(input int ni, input int nd, input int nb);
    fill(ni, nd, nb);
    run_window();
    model_window();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; freqInc = 1'b0; freqDec = 1'b0;

    // Reset held two cycles, then reset overriding enable, then release
    repeat (2) @(negedge refClk);
    check_out("reset", INIT_CODE, 1'b0, 1'b0);
    enable = 1'b1;
    @(negedge refClk);
    check_out("reset_over_enable", INIT_CODE, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge refClk);
    check_out("enable_start", INIT_CODE, 1'b0, 1'b1);

    // Directed windows: {restart, inc, dec, both, expected code, expected done}
    tbl.push_back('{1'b0, 16, 0, 0, 160, 1'b0});
    tbl.push_back('{1'b0, 16, 0, 0, 192, 1'b0});
    tbl.push_back('{1'b0, 16, 0, 0, 224, 1'b0});
    tbl.push_back('{1'b0, 16, 0, 0, 255, 1'b0});
    tbl.push_back('{1'b0, 16, 0, 0, 255, 1'b0});
    tbl.push_back('{1'b1, 16, 0, 0, 160, 1'b0});
    tbl.push_back('{1'b0, 0, 16, 0, 144, 1'b0});
    tbl.push_back('{1'b0, 16, 0, 0, 152, 1'b0});
    tbl.push_back('{1'b0, 5, 4, 0, 152, 1'b0});
    tbl.push_back('{1'b0, 5, 4, 0, 152, 1'b0});
    tbl.push_back('{1'b0, 5, 4, 0, 152, 1'b0});
    tbl.push_back('{1'b0, 5, 4, 0, 152, 1'b1});
    tbl.push_back('{1'b0, 0, 10, 0, 151, 1'b0});
    tbl.push_back('{1'b0, 16, 0, 0, 152, 1'b0});
    tbl.push_back('{1'b0, 0, 0, 32, 152, 1'b0});
    tbl.push_back('{1'b1, 0, 16, 0, 96, 1'b0});
    tbl.push_back('{1'b0, 0, 16, 0, 64, 1'b0});
    tbl.push_back('{1'b0, 0, 16, 0, 32, 1'b0});
    tbl.push_back('{1'b0, 0, 16, 0, 0, 1'b0});
    tbl.push_back('{1'b0, 0, 16, 0, 0, 1'b0});
    tbl.push_back('{1'b0, 16, 0, 0, 16, 1'b0});
    tbl.push_back('{1'b0, 0, 16, 0, 8, 1'b0});
    tbl.push_back('{1'b0, 0, 16, 0, 0, 1'b0});
    tbl.push_back('{1'b0, 0, 16, 0, 0, 1'b0});
    tbl.push_back('{1'b0, 6, 4, 0, 0, 1'b0});
    tbl.push_back('{1'b0, 7, 4, 0, 4, 1'b0});
    tbl.push_back('{1'b0, 4, 7, 0, 2, 1'b0});
    tbl.push_back('{1'b0, 4, 6, 0, 2, 1'b0});

    model_reset();
    foreach (tbl[i]) begin
      if (tbl[i].rst) restart();
      do_window(tbl[i].ni, tbl[i].nd, tbl[i].nb);
      check_out($sformatf("vec%0d", i), tbl[i].code, tbl[i].done, 1'b1);
    end

    // Enable dropped mid-SAMPLE while locked, then re-enable restarts with full step
    restart();
    do_window(16, 0, 0);
    do_window(0, 16, 0);
    repeat (4) do_window(5, 4, 0);
    check_out("locked", 144, 1'b1, 1'b1);
    freqInc = 1'b1;
    repeat (20) @(negedge refClk);
    enable = 1'b0;
    @(negedge refClk);
    freqInc = 1'b0;
    check_out("disable", 144, 1'b0, 1'b0);
    repeat (3) @(negedge refClk);
    check_out("idle_hold", 144, 1'b0, 1'b0);
    enable = 1'b1;
    @(negedge refClk);
    check_out("reenable", 144, 1'b0, 1'b1);
    do_window(16, 0, 0);
    check_out("reenable_step", 176, 1'b0, 1'b1);

    // Reset asserted mid-SETTLE
    repeat (5) @(negedge refClk);
    reset = 1'b1;
    @(negedge refClk);
    check_out("reset_mid_settle", INIT_CODE, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge refClk);
    model_reset();
    check_out("after_reset", INIT_CODE, 1'b0, 1'b1);
    do_window(16, 0, 0);
    check_out("after_reset_win", 160, 1'b0, 1'b1);

    // Randomized windows and enable drops against the reference model
    for (int w = 0; w < 60; w++) begin
      if ($urandom_range(0, 7) == 0) begin
        int r;
        r = $urandom_range(0, 48);
        for (int c = 0; c < r; c++) begin
          freqInc = 1'($urandom_range(0, 1));
          freqDec = 1'($urandom_range(0, 1));
          @(negedge refClk);
        end
        enable = 1'b0;
        @(negedge refClk);
        freqInc = 1'b0;
        freqDec = 1'b0;
        model_disable();
        check_out($sformatf("rnd%0d drop", w), m_code, 1'b0, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge refClk);
        enable = 1'b1;
        @(negedge refClk);
      end else begin
        int pi, pd;
        pi = $urandom_range(0, 8);
        pd = ($urandom_range(0, 1) == 1) ? pi : int'($urandom_range(0, 8));
        fill_random(pi, pd);
        run_window();
        model_window();
        check_out($sformatf("rnd%0d", w), m_code, m_done, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
